// File: rtl/vsq_quantizer_if.sv
// Stream bundle between the activation producer, vsq_quantizer and the operand buffer.
// Latency: n/a (wires only); slave side is the quantizer, master side drives beats and consumes vectors.
// Backpressure: valid/ready on both the input beat stream and the output vector stream.
interface vsq_quantizer_if #(
    parameter int DATA_W         = 11,
    parameter int ELEMS_PER_BEAT = 8
);
    logic                             i_valid;
    logic                             o_ready;
    logic [ELEMS_PER_BEAT*DATA_W-1:0] i_data;
    logic                             o_valid;
    logic                             i_ready;
    logic [255:0]                     o_vec;
    logic [7:0]                       o_scale;

    modport slave (
        input  i_valid,
        input  i_data,
        input  i_ready,
        output o_ready,
        output o_valid,
        output o_vec,
        output o_scale
    );

    modport master (
        output i_valid,
        output i_data,
        output i_ready,
        input  o_ready,
        input  o_valid,
        input  o_vec,
        input  o_scale
    );
endinterface

// File: rtl/vsq_quantizer.sv
// INT4_VSQ producer: collects 64 signed activations, emits packed INT4 + 8-bit scale ceil(absmax/7).
// Latency: last beat at edge T -> o_valid after edge T+DATA_W+18 (divider); T+1 with VSQ_SCALE_POW2_EN.
// Backpressure: one vector in flight; o_ready low from last beat until the output handshake completes.
module vsq_quantizer #(
    parameter int DATA_W         = 11,
    parameter int ELEMS_PER_BEAT = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    vsq_quantizer_if.slave bus
);

    localparam int N_ELEMS = 64;
    localparam int BEATS   = N_ELEMS / ELEMS_PER_BEAT;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    // x (DATA_W signed) times r (17-bit unsigned) plus a sign bit of headroom
    localparam int PROD_W  = DATA_W + 18;

    localparam logic signed [PROD_W-1:0] Q_MAX = 7;
    localparam logic signed [PROD_W-1:0] Q_MIN = -8;

    typedef enum logic [2:0] {
        S_COLLECT,
        S_DIV_S,
        S_DIV_R,
        S_QUANT,
        S_OUT
    } state_t;

    state_t                    state;
    logic [CNT_W-1:0]          beat_cnt;
    logic [DATA_W-1:0]         absmax;       // unsigned: |-2^(DATA_W-1)| fits without wrap
    logic signed [DATA_W-1:0]  elems [N_ELEMS];
    logic [7:0]                scale_q;      // working scale s
    logic [16:0]               recip_q;      // working reciprocal r = floor(2^16/s)
    logic                      ready_q;
    logic                      valid_q;
    logic [255:0]              vec_q;
    logic [7:0]                out_scale_q;

    logic                      accept;
    logic                      last_beat;
    logic [DATA_W-1:0]         beat_max;
    logic [DATA_W-1:0]         absmax_nx;
    logic [255:0]              qvec;

    assign accept    = bus.i_valid && ready_q;
    assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));
    assign absmax_nx = (beat_max > absmax) ? beat_max : absmax;

    assign bus.o_ready = ready_q;
    assign bus.o_valid = valid_q;
    assign bus.o_vec   = vec_q;
    assign bus.o_scale = out_scale_q;

    // Largest magnitude among the lanes of the incoming beat
    always_comb begin
        logic [DATA_W-1:0] lane;
        logic [DATA_W-1:0] mag;
        beat_max = '0;
        lane     = '0;
        mag      = '0;
        for (int k = 0; k < ELEMS_PER_BEAT; k++) begin
            lane = bus.i_data[k*DATA_W +: DATA_W];
            mag  = lane[DATA_W-1] ? (~lane + DATA_W'(1)) : lane;
            if (mag > beat_max) begin
                beat_max = mag;
            end
        end
    end

    // Element buffer: beat b lane k lands in element b*ELEMS_PER_BEAT+k
    always_ff @(posedge i_clk) begin
        if (accept) begin
            for (int k = 0; k < ELEMS_PER_BEAT; k++) begin
                elems[int'(beat_cnt)*ELEMS_PER_BEAT + k] <= bus.i_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Round-to-nearest multiply by the reciprocal, then saturate to INT4
    always_comb begin
        logic [PROD_W-1:0]        prod;
        logic [PROD_W-1:0]        rnd;
        logic signed [PROD_W-1:0] sh;
        logic [3:0]               q;
        qvec = '0;
        prod = '0;
        rnd  = '0;
        sh   = '0;
        q    = '0;
        for (int e = 0; e < N_ELEMS; e++) begin
            // Modular product of the sign-extended operands gives the exact signed result
            prod = {{(PROD_W-DATA_W){elems[e][DATA_W-1]}}, elems[e]}
                 * {{(PROD_W-17){1'b0}}, recip_q};
            rnd  = prod + PROD_W'(32'h8000);
            sh   = $signed(rnd) >>> 16;
            if (sh > Q_MAX) begin
                q = 4'sd7;
            end else if (sh < Q_MIN) begin
                q = 4'h8;
            end else begin
                q = sh[3:0];
            end
            qvec[4*e +: 4] = q;
        end
    end

`ifdef VSQ_SCALE_POW2_EN
    // Power-of-two scale: smallest k with 7*2^k >= M, capped at 7 so s stays within 8 bits
    // (large M then clips through sat4 instead of widening the scale field).
    logic [2:0] pow_k;

    // Exponent search over the candidate scales
    always_comb begin
        pow_k = 3'd7;
        for (int j = 6; j >= 0; j--) begin
            if ((32'd7 << j) >= 32'(absmax_nx)) begin
                pow_k = 3'(j);
            end
        end
    end
`else
    // Shared restoring divider: one quotient bit per cycle, dividend left-aligned in div_num,
    // quotient bits shifted in at the bottom.
    logic [16:0] div_num;
    logic [7:0]  div_rem;
    logic [7:0]  div_den;
    logic [4:0]  step_cnt;
    logic [8:0]  rem_sh;
    logic        rem_ge;
    logic [7:0]  rem_nx;
    logic [16:0] num_nx;
    logic [7:0]  quo_s;

    assign rem_sh = {div_rem, div_num[16]};
    assign rem_ge = (rem_sh >= {1'b0, div_den});
    assign rem_nx = rem_ge ? 8'(rem_sh - {1'b0, div_den}) : rem_sh[7:0];
    assign num_nx = {div_num[15:0], rem_ge};
    // An all-zero vector would give s=0; force s=1 so the reciprocal is defined
    assign quo_s  = (num_nx[7:0] == 8'd0) ? 8'd1 : num_nx[7:0];
`endif

    // Control FSM: collect beats, derive s and r, quantize, hold the result until taken
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_COLLECT;
            beat_cnt    <= '0;
            absmax      <= '0;
            scale_q     <= '0;
            recip_q     <= '0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
            vec_q       <= '0;
            out_scale_q <= '0;
`ifndef VSQ_SCALE_POW2_EN
            div_num     <= '0;
            div_rem     <= '0;
            div_den     <= '0;
            step_cnt    <= '0;
`endif
        end else begin
            case (state)
                S_COLLECT: begin
                    if (accept) begin
                        absmax <= absmax_nx;
                        if (last_beat) begin
                            beat_cnt <= '0;
                            ready_q  <= 1'b0;
`ifdef VSQ_SCALE_POW2_EN
                            scale_q  <= 8'd1 << pow_k;
                            recip_q  <= 17'h10000 >> pow_k;
                            state    <= S_QUANT;
`else
                            // (M+6)/7 == ceil(M/7)
                            div_num  <= 17'(absmax_nx + DATA_W'(6)) << (17 - DATA_W);
                            div_rem  <= '0;
                            div_den  <= 8'd7;
                            step_cnt <= '0;
                            state    <= S_DIV_S;
`endif
                        end else begin
                            beat_cnt <= beat_cnt + CNT_W'(1);
                        end
                    end
                end
`ifndef VSQ_SCALE_POW2_EN
                S_DIV_S: begin
                    if (step_cnt == 5'(DATA_W - 1)) begin
                        scale_q  <= quo_s;
                        div_num  <= 17'h10000;
                        div_rem  <= '0;
                        div_den  <= quo_s;
                        step_cnt <= '0;
                        state    <= S_DIV_R;
                    end else begin
                        div_num  <= num_nx;
                        div_rem  <= rem_nx;
                        step_cnt <= step_cnt + 5'd1;
                    end
                end
                S_DIV_R: begin
                    div_num  <= num_nx;
                    div_rem  <= rem_nx;
                    step_cnt <= step_cnt + 5'd1;
                    if (step_cnt == 5'd16) begin
                        recip_q <= num_nx;
                        state   <= S_QUANT;
                    end
                end
`endif
                S_QUANT: begin
                    vec_q       <= qvec;
                    out_scale_q <= scale_q;
                    valid_q     <= 1'b1;
                    state       <= S_OUT;
                end
                S_OUT: begin
                    if (bus.i_ready) begin
                        valid_q  <= 1'b0;
                        ready_q  <= 1'b1;
                        absmax   <= '0;
                        beat_cnt <= '0;
                        state    <= S_COLLECT;
                    end
                end
                default: begin
                    state <= S_COLLECT;
                end
            endcase
        end
    end

endmodule
